// File: rtl/axil_reg_slave.sv
// AXI4-Lite register-file responder: ID, CTRL, W1C IRQ status, IRQ enable,
// user RW control words and user RO status words, plus a masked interrupt.
// Ports:
//   s_axil_aclk/s_axil_rst        clock, async active-high reset
//   s_axil_aw*/w*/b*              write address, data, response channels
//   s_axil_ar*/r*                 read address and data channels
//   ctrl_start, ctrl              CTRL start pulse and CTRL value (bit0 = 0)
//   user_ctrl                     RW regs 4..REG_NUM/2-1, index 4 in LSBs
//   user_stat                     RO regs REG_NUM/2..REG_NUM-1
//   irq_src, irq                  interrupt sources, registered masked irq
module axil_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'h0305_0001,
  parameter int IRQ_NUM    = 8
) (
  input  logic                  s_axil_aclk,
  input  logic                  s_axil_rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic                  ctrl_start,
  output logic [DATA_WIDTH-1:0] ctrl,
  output logic [(REG_NUM/2-4)*DATA_WIDTH-1:0] user_ctrl,
  input  logic [(REG_NUM/2)*DATA_WIDTH-1:0]   user_stat,
  input  logic [IRQ_NUM-1:0]    irq_src,
  output logic                  irq
);

  localparam int IDX_W  = $clog2(REG_NUM);
  localparam int STRB_W = DATA_WIDTH/8;
  localparam int USR_RW = REG_NUM/2 - 4;
  localparam int USR_RO = REG_NUM/2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  aw_full;
  logic                  w_full;
  logic [ADDR_WIDTH-1:2] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;

  logic [DATA_WIDTH-1:0] ctrl_r;
  logic [IRQ_NUM-1:0]    irq_status;
  logic [IRQ_NUM-1:0]    irq_enable;
  logic [USR_RW-1:0][DATA_WIDTH-1:0] user_rw;

  logic aw_hs, w_hs, ar_hs, commit, wr_ok;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic w_err, r_err;

  logic [DATA_WIDTH-1:0] wmask, ctrl_new, en_new;
  logic [DATA_WIDTH-1:0] stat_ext, en_ext;
  logic [IRQ_NUM-1:0]    irq_clr, irq_status_nxt;
  logic sel_ctrl, sel_stat, sel_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;
  logic                  unused_ok;

  // Readies are forced low while reset is held, independent of the clock.
  assign s_axil_awready = ~aw_full & ~s_axil_rst;
  assign s_axil_wready  = ~w_full & ~s_axil_rst;
  assign s_axil_arready = ~s_axil_rvalid & ~s_axil_rst;

  assign aw_hs  = s_axil_awvalid & s_axil_awready;
  assign w_hs   = s_axil_wvalid & s_axil_wready;
  assign ar_hs  = s_axil_arvalid & s_axil_arready;
  assign commit = aw_full & w_full & ~s_axil_bvalid;

  assign w_idx = aw_addr[IDX_W+1:2];
  assign w_err = |aw_addr[ADDR_WIDTH-1:IDX_W+2];
  assign wr_ok = commit & ~w_err;

  assign r_idx = s_axil_araddr[IDX_W+1:2];
  assign r_err = |s_axil_araddr[ADDR_WIDTH-1:IDX_W+2];

  assign stat_ext = DATA_WIDTH'(irq_status);
  assign en_ext   = DATA_WIDTH'(irq_enable);

  assign ctrl      = ctrl_r;
  assign user_ctrl = user_rw;

  assign unused_ok = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0], en_new};

  always_comb begin
    wmask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      wmask[b*8 +: 8] = {8{w_strb[b]}};
    end
    ctrl_new = (ctrl_r & ~wmask) | (w_data & wmask);
    en_new   = (en_ext & ~wmask) | (w_data & wmask);
    sel_ctrl = wr_ok && (w_idx == IDX_W'(1));
    sel_stat = wr_ok && (w_idx == IDX_W'(2));
    sel_en   = wr_ok && (w_idx == IDX_W'(3));
    irq_clr  = '0;
    if (sel_stat) begin
      irq_clr = w_data[IRQ_NUM-1:0] & wmask[IRQ_NUM-1:0];
    end
    // A source seen on the clearing edge re-sets the bit.
    irq_status_nxt = (irq_status & ~irq_clr) | irq_src;
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (r_err) begin
      rd_resp = RESP_SLVERR;
    end else if (r_idx == IDX_W'(0)) begin
      rd_data = ID_VALUE;
    end else if (r_idx == IDX_W'(1)) begin
      rd_data = ctrl_r;
    end else if (r_idx == IDX_W'(2)) begin
      rd_data = stat_ext;
    end else if (r_idx == IDX_W'(3)) begin
      rd_data = en_ext;
    end else begin
      for (int i = 0; i < USR_RW; i++) begin
        if (r_idx == IDX_W'(4 + i)) begin
          rd_data = user_rw[i];
        end
      end
      for (int i = 0; i < USR_RO; i++) begin
        if (r_idx == IDX_W'(USR_RO + i)) begin
          rd_data = user_stat[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge s_axil_aclk or posedge s_axil_rst) begin
    if (s_axil_rst) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      aw_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= s_axil_awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end
      if (commit) begin
        aw_full       <= 1'b0;
        w_full        <= 1'b0;
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= w_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_axil_aclk or posedge s_axil_rst) begin
    if (s_axil_rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_data;
      s_axil_rresp  <= rd_resp;
    end else if (s_axil_rvalid && s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge s_axil_aclk or posedge s_axil_rst) begin
    if (s_axil_rst) begin
      ctrl_r     <= '0;
      ctrl_start <= 1'b0;
      irq_status <= '0;
      irq_enable <= '0;
      user_rw    <= '0;
      irq        <= 1'b0;
    end else begin
      ctrl_start <= 1'b0;
      irq        <= |(irq_status & irq_enable);
      irq_status <= irq_status_nxt;
      if (sel_ctrl) begin
        // Bit0 is a self-clearing start request.
        ctrl_r     <= {ctrl_new[DATA_WIDTH-1:1], 1'b0};
        ctrl_start <= ctrl_new[0];
      end
      if (sel_en) begin
        irq_enable <= en_new[IRQ_NUM-1:0];
      end
      for (int i = 0; i < USR_RW; i++) begin
        if (wr_ok && (w_idx == IDX_W'(4 + i))) begin
          user_rw[i] <= (user_rw[i] & ~wmask) | (w_data & wmask);
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Scoreboard bench for axil_reg_slave: directed AXI-Lite traffic with
// expected B/R responses queued and checked by an independent monitor.
module tb_axil_reg_slave;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  awaddr = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b1;
  logic [31:0]  araddr = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b1;
  logic         ctrl_start;
  logic [31:0]  ctrl;
  logic [127:0] user_ctrl;
  logic [255:0] user_stat = '0;
  logic [7:0]   irq_src = '0;
  logic         irq;

  axil_reg_slave dut (
    .s_axil_aclk    (clk),
    .s_axil_rst     (rst),
    .s_axil_awaddr  (awaddr),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .ctrl_start     (ctrl_start),
    .ctrl           (ctrl),
    .user_ctrl      (user_ctrl),
    .user_stat      (user_stat),
    .irq_src        (irq_src),
    .irq            (irq)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic [1:0] bq[$];
  rexp_t      rq[$];
  rexp_t      re;
  logic [1:0] be;
  int errors = 0;
  int checks = 0;
  int b_hs = 0;
  int start_cnt = 0;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout", name);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ctrl_start) start_cnt++;
      if (bvalid && bready) begin
        b_hs++;
        if (bq.size() == 0) begin
          fail_now("b_unexpected");
        end else begin
          be = bq.pop_front();
          check("bresp", 128'(bresp), 128'(be));
        end
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          fail_now("r_unexpected");
        end else begin
          re = rq.pop_front();
          check("rdata", 128'(rdata), 128'(re.d));
          check("rresp", 128'(rresp), 128'(re.r));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] a);
    bit ok = 0;
    awaddr = a;
    awvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (awready) begin ok = 1; break; end
    end
    if (!ok) fail_now("aw_handshake");
    step(1);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (wready) begin ok = 1; break; end
    end
    if (!ok) fail_now("w_handshake");
    step(1);
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit ok = 0;
    araddr = a;
    arvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    if (!ok) fail_now("ar_handshake");
    step(1);
    arvalid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bq.size() == 0 && rq.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      fail_now("drain");
      bq.delete();
      rq.delete();
    end
    step(1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] r);
    bq.push_back(r);
    fork
      send_aw(a);
      send_w(d, s);
    join
    drain();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] r);
    rq.push_back('{d: d, r: r});
    send_ar(a);
    drain();
  endtask

  logic [127:0] uc_exp;
  int b0, s0;
  bit seen;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 128'(awready), 128'(0));
    check("rst_wready", 128'(wready), 128'(0));
    check("rst_arready", 128'(arready), 128'(0));
    check("rst_valids", 128'({bvalid, rvalid}), 128'(0));
    check("rst_irq_start", 128'({irq, ctrl_start}), 128'(0));
    step(1);
    rst = 1'b0;
    step(1);

    user_stat[31:0]    = 32'hCAFE_F00D;
    user_stat[255:224] = 32'h0BAD_BEEF;

    rd(32'h00, 32'h0305_0001, OK);
    rd(32'h04, 32'h0, OK);
    rd(32'h08, 32'h0, OK);
    rd(32'h0C, 32'h0, OK);

    // W first, AW three cycles later, partial strobes.
    b0 = b_hs;
    bq.push_back(OK);
    send_w(32'hDEAD_BEEF, 4'b0011);
    step(2);
    send_aw(32'h10);
    drain();
    step(3);
    check("w_before_aw_user", user_ctrl[31:0], 128'h0000_BEEF);
    check("w_before_aw_bcount", 128'(b_hs - b0), 128'(1));

    // Response back-pressure with a second AW parked.
    bready = 1'b0;
    bq.push_back(OK);
    fork
      send_aw(32'h14);
      send_w(32'h1234_5678, 4'hF);
    join
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bvalid) begin seen = 1; break; end
    end
    if (!seen) fail_now("bvalid_rise");
    step(1);
    send_aw(32'h18);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("hold_bvalid", 128'(bvalid), 128'(1));
      check("hold_bresp", 128'(bresp), 128'(OK));
      check("hold_awready", 128'(awready), 128'(0));
    end
    step(1);
    bready = 1'b1;
    bq.push_back(OK);
    send_w(32'hA5A5_A5A5, 4'hF);
    drain();
    uc_exp = {32'h0, 32'hA5A5_A5A5, 32'h1234_5678, 32'h0000_BEEF};
    check("user_ctrl_after_hold", user_ctrl, uc_exp);

    // CTRL start pulse.
    s0 = start_cnt;
    wr(32'h04, 32'h5, 4'hF, OK);
    step(2);
    check("ctrl_start_pulses", 128'(start_cnt - s0), 128'(1));
    check("ctrl_value", 128'(ctrl), 128'h4);
    rd(32'h04, 32'h4, OK);

    // Interrupt status, enable, masking and W1C.
    irq_src[3] = 1'b1;
    step(1);
    irq_src[3] = 1'b0;
    step(2);
    rd(32'h08, 32'h8, OK);
    check("irq_masked", 128'(irq), 128'(0));
    wr(32'h0C, 32'hFFFF_FF08, 4'hF, OK);
    step(2);
    check("irq_enabled", 128'(irq), 128'(1));
    rd(32'h0C, 32'h8, OK);
    wr(32'h08, 32'h8, 4'hF, OK);
    step(2);
    check("irq_cleared", 128'(irq), 128'(0));
    rd(32'h08, 32'h0, OK);

    // Out of range and read-only targets.
    wr(32'h40, 32'hFFFF_FFFF, 4'hF, ERR);
    rd(32'h40, 32'h0, ERR);
    rd(32'h7C, 32'h0, ERR);
    check("oor_user_ctrl", user_ctrl, uc_exp);
    check("oor_ctrl", 128'(ctrl), 128'h4);
    rd(32'h08, 32'h0, OK);
    wr(32'h20, 32'h1111_1111, 4'hF, OK);
    rd(32'h20, 32'hCAFE_F00D, OK);
    rd(32'h22, 32'hCAFE_F00D, OK);
    rd(32'h3C, 32'h0BAD_BEEF, OK);
    wr(32'h00, 32'h0, 4'hF, OK);
    rd(32'h00, 32'h0305_0001, OK);

    // Source high exactly on the W1C commit edge: set wins.
    bq.push_back(OK);
    fork
      send_aw(32'h08);
      send_w(32'h1, 4'hF);
      begin
        step(1);
        irq_src[0] = 1'b1;
        step(1);
        irq_src[0] = 1'b0;
      end
    join
    drain();
    rd(32'h08, 32'h1, OK);
    wr(32'h08, 32'h1, 4'hF, OK);
    rd(32'h08, 32'h0, OK);

    // Read and write of the same register on the same edge.
    bq.push_back(OK);
    rq.push_back('{d: 32'h0000_BEEF, r: OK});
    fork
      send_aw(32'h10);
      send_w(32'h600D_CAFE, 4'hF);
      begin
        step(1);
        send_ar(32'h10);
      end
    join
    drain();
    rd(32'h10, 32'h600D_CAFE, OK);

    // Reset in the middle of a write.
    irq_src[3] = 1'b1;
    step(1);
    irq_src[3] = 1'b0;
    step(2);
    check("pre_rst_irq", 128'(irq), 128'(1));
    send_aw(32'h14);
    rst = 1'b1;
    #2;
    check("mid_rst_readies", 128'({awready, wready, arready}), 128'(0));
    check("mid_rst_valids", 128'({bvalid, rvalid}), 128'(0));
    check("mid_rst_resp", 128'({bresp, rresp, rdata}), 128'(0));
    check("mid_rst_irq", 128'({irq, ctrl_start}), 128'(0));
    check("mid_rst_ctrl", 128'(ctrl), 128'(0));
    check("mid_rst_user", user_ctrl, 128'(0));
    step(2);
    rst = 1'b0;
    step(1);
    rd(32'h04, 32'h0, OK);
    rd(32'h0C, 32'h0, OK);
    rd(32'h10, 32'h0, OK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
